demux4_stream: RTL and testbench



---
 rtl/demux4_stream_if.sv | 69 ++++++
 rtl/demux4_stream.sv | 74 +++++++
 tb/tb_demux4_stream.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/demux4_stream_if.sv
// Stream bundle for demux4_stream: one producer port, four consumer slots.
// in_bcast exists only when DEMUX4_BROADCAST_EN is defined.
interface demux4_stream_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
`ifdef DEMUX4_BROADCAST_EN
  logic             in_bcast;
`endif
  logic [WIDTH-1:0] outa;
  logic [WIDTH-1:0] outb;
  logic [WIDTH-1:0] outc;
  logic [WIDTH-1:0] outd;
  logic             outa_valid;
  logic             outb_valid;
  logic             outc_valid;
  logic             outd_valid;
  logic             outa_ready;
  logic             outb_ready;
  logic             outc_ready;
  logic             outd_ready;

  modport slave (
    input  in_data,
    input  in_sel,
    input  in_valid,
    output in_ready,
`ifdef DEMUX4_BROADCAST_EN
    input  in_bcast,
`endif
    output outa,
    output outb,
    output outc,
    output outd,
    output outa_valid,
    output outb_valid,
    output outc_valid,
    output outd_valid,
    input  outa_ready,
    input  outb_ready,
    input  outc_ready,
    input  outd_ready
  );

  modport master (
    output in_data,
    output in_sel,
    output in_valid,
    input  in_ready,
`ifdef DEMUX4_BROADCAST_EN
    output in_bcast,
`endif
    input  outa,
    input  outb,
    input  outc,
    input  outd,
    input  outa_valid,
    input  outb_valid,
    input  outc_valid,
    input  outd_valid,
    output outa_ready,
    output outb_ready,
    output outc_ready,
    output outd_ready
  );
endinterface

// File: rtl/demux4_stream.sv
// 1-to-4 stream demux, one registered holding slot per output.
// Optional broadcast to all slots: define DEMUX4_BROADCAST_EN.
module demux4_stream #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  demux4_stream_if.slave bus
);

  logic [3:0]       valid_q;
  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       rdy;
  logic [3:0]       drain;
  logic [3:0]       free;
  logic [3:0]       sel_oh;
  logic [3:0]       tgt;
  logic [3:0]       load;
  logic             accept;

  assign rdy = {bus.outd_ready, bus.outc_ready,
                bus.outb_ready, bus.outa_ready};
  assign drain = valid_q & rdy;
  assign free  = ~valid_q | drain;

  always_comb begin
    sel_oh = 4'b0000;
    unique case (bus.in_sel)
      2'd0: sel_oh = 4'b0001;
      2'd1: sel_oh = 4'b0010;
      2'd2: sel_oh = 4'b0100;
      2'd3: sel_oh = 4'b1000;
    endcase
  end

`ifdef DEMUX4_BROADCAST_EN
  assign tgt = bus.in_bcast ? 4'b1111 : sel_oh;
`else
  assign tgt = sel_oh;
`endif

  // every targeted slot must be free for the word to go in
  assign bus.in_ready = rst_n && ((free & tgt) == tgt);
  assign accept = bus.in_valid && bus.in_ready;
  assign load   = tgt & {4{accept}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          data_q[i]  <= bus.in_data;
          valid_q[i] <= 1'b1;
        end else if (drain[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.outa = data_q[0];
  assign bus.outb = data_q[1];
  assign bus.outc = data_q[2];
  assign bus.outd = data_q[3];
  assign bus.outa_valid = valid_q[0];
  assign bus.outb_valid = valid_q[1];
  assign bus.outc_valid = valid_q[2];
  assign bus.outd_valid = valid_q[3];

endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream: reset, routing, backpressure,
// throughput, mid-run reset, slot independence and broadcast.
module tb_demux4_stream;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  demux4_stream_if #(.WIDTH(16)) bus ();

  demux4_stream #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd0;
    bus.in_data = 16'h9999;
`ifdef DEMUX4_BROADCAST_EN
    bus.in_bcast = 1'b0;
`endif
    bus.outa_ready = 1'b0;
    bus.outb_ready = 1'b0;
    bus.outc_ready = 1'b0;
    bus.outd_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      nxt();
      #1;
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_valid", {bus.outa_valid, bus.outb_valid,
                        bus.outc_valid, bus.outd_valid}, 0);
      chk("rst_data", bus.outa | bus.outb | bus.outc | bus.outd, 0);
    end

    // routing
    rst_n = 1'b1;
    bus.in_sel = 2'd0;
    bus.in_data = 16'h1111;
    #1 chk("first_ready", bus.in_ready, 1);
    nxt();
    bus.in_sel = 2'd1;
    bus.in_data = 16'h2222;
    #1 chk("outa", bus.outa, 16'h1111);
    chk("outa_v", bus.outa_valid, 1);
    chk("rdy_b", bus.in_ready, 1);
    nxt();
    bus.in_sel = 2'd2;
    bus.in_data = 16'h3333;
    #1 chk("outb", bus.outb, 16'h2222);
    chk("outb_v", bus.outb_valid, 1);
    nxt();
    bus.in_sel = 2'd3;
    bus.in_data = 16'h4444;
    #1 chk("outc", bus.outc, 16'h3333);
    chk("outc_v", bus.outc_valid, 1);
    nxt();
    bus.in_valid = 1'b0;
    #1 chk("outd", bus.outd, 16'h4444);
    chk("outd_v", bus.outd_valid, 1);

    // backpressure on slot b
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd1;
    bus.in_data = 16'h5555;
    #1 chk("bp_ready0", bus.in_ready, 0);
    nxt();
    #1 chk("bp_hold", bus.outb, 16'h2222);
    chk("bp_ready1", bus.in_ready, 0);
    bus.outb_ready = 1'b1;
    #1 chk("bp_release", bus.in_ready, 1);
    nxt();
    bus.outb_ready = 1'b0;
    bus.in_valid = 1'b0;
    #1 chk("bp_outb", bus.outb, 16'h5555);
    chk("bp_outb_v", bus.outb_valid, 1);

    // throughput on slot c, draining and refilling each cycle
    bus.outc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel = 2'd2;
      bus.in_data = 16'hC000 + 16'(i);
      #1 chk("tp_ready", bus.in_ready, 1);
      chk("tp_outc", bus.outc,
          (i == 0) ? 32'h3333 : 32'hC000 + 32'(i - 1));
      chk("tp_outc_v", bus.outc_valid, 1);
      nxt();
    end
    bus.in_valid = 1'b0;
    #1 chk("tp_last", bus.outc, 16'hC007);
    chk("tp_last_v", bus.outc_valid, 1);
    nxt();
    #1 chk("tp_empty", bus.outc_valid, 0);
    chk("tp_keep", bus.outc, 16'hC007);
    bus.outc_ready = 1'b0;

    // mid-operation reset with a and d holding words
    chk("mr_pre", {bus.outa_valid, bus.outd_valid}, 2'b11);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd0;
    bus.in_data = 16'h8888;
    #1 chk("mr_ready", bus.in_ready, 0);
    nxt();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1 chk("mr_valid", {bus.outa_valid, bus.outb_valid,
                        bus.outc_valid, bus.outd_valid}, 0);
    chk("mr_data", bus.outa | bus.outd, 0);
    nxt();
    #1 chk("mr_stay", {bus.outa_valid, bus.outd_valid}, 0);

    // stalled slot b must not block slot a
    bus.in_valid = 1'b1;
    bus.in_sel = 2'd1;
    bus.in_data = 16'h6666;
    #1 chk("ind_b", bus.in_ready, 1);
    nxt();
    bus.in_sel = 2'd0;
    bus.in_data = 16'h7777;
    #1 chk("ind_a", bus.in_ready, 1);
    nxt();
    bus.in_valid = 1'b0;
    #1 chk("ind_outa", bus.outa, 16'h7777);
    chk("ind_outb", bus.outb, 16'h6666);

`ifdef DEMUX4_BROADCAST_EN
    bus.outa_ready = 1'b1;
    bus.outb_ready = 1'b1;
    nxt();
    bus.outa_ready = 1'b0;
    bus.outb_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_bcast = 1'b1;
    bus.in_sel = 2'd2;
    bus.in_data = 16'hABCD;
    #1 chk("bc_ready", bus.in_ready, 1);
    nxt();
    bus.in_data = 16'h1234;
    #1 chk("bc_outs", {bus.outa, bus.outb}, 32'hABCDABCD);
    chk("bc_outs2", {bus.outc, bus.outd}, 32'hABCDABCD);
    chk("bc_valid", {bus.outa_valid, bus.outb_valid,
                     bus.outc_valid, bus.outd_valid}, 4'hF);
    chk("bc_full", bus.in_ready, 0);
    bus.outb_ready = 1'b1;
    bus.outc_ready = 1'b1;
    bus.outd_ready = 1'b1;
    #1 chk("bc_a_stall", bus.in_ready, 0);
    nxt();
    #1 chk("bc_a_held", bus.in_ready, 0);
    chk("bc_a_v", bus.outa_valid, 1);
    chk("bc_b_v", bus.outb_valid, 0);
    bus.outa_ready = 1'b1;
    #1 chk("bc_go", bus.in_ready, 1);
    nxt();
    bus.in_valid = 1'b0;
    bus.in_bcast = 1'b0;
    bus.outa_ready = 1'b0;
    bus.outb_ready = 1'b0;
    bus.outc_ready = 1'b0;
    bus.outd_ready = 1'b0;
    #1 chk("bc2_outs", {bus.outa, bus.outd}, 32'h12341234);
    chk("bc2_valid", {bus.outa_valid, bus.outb_valid,
                      bus.outc_valid, bus.outd_valid}, 4'hF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
